stack_ctl: RTL and testbench

//  Synchronous controller that shares one edge-strobed LIFO stack between NREQ requesters.
//  It arbitrates round-robin and sequences PUSH/POP/DUP/PEEK into clean one-cycle stk_push/stk_pop pulses.
//  It tracks occupancy and returns results per requester over a valid/ready request + pulsed response.

---
 rtl/stack_ctl_pkg.sv | 27 ++
 rtl/stack_ctl_rr_arbiter.sv | 52 +++++
 rtl/stack_ctl.sv | 145 ++++++++++++++
 tb/tb_stack_ctl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctl_pkg.sv
// Shared types and constants for the stack_ctl controller.
// Optional guard feature is selected with the STACK_CTL_GUARD_EN macro.
package stack_ctl_pkg;

    typedef enum logic [1:0] {
        PUSH = 2'd0,
        POP  = 2'd1,
        DUP  = 2'd2,
        PEEK = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WORD_DEF  = 8;
    localparam int DEPTH_DEF = 8;
    localparam int NREQ_DEF  = 2;
    localparam int DEPTH_W   = $clog2(DEPTH_DEF + 1);

    function automatic logic grows_stack(op_e op);
        return (op == PUSH) || (op == DUP);
    endfunction

endpackage

// File: rtl/stack_ctl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search begins at the requester after the last winner.
module rr_arbiter
    import stack_ctl_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        win     = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                win          = PW'(idx);
                grant_o[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments with an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_ctl.sv
// Shares one edge-strobed LIFO between NREQ requesters (IDLE -> EXEC -> DONE sequencer).
// Define STACK_CTL_GUARD_EN to reject overflowing/underflowing ops instead of issuing them.
module stack_ctl
    import stack_ctl_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int DEPTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [2*NREQ-1:0]          req_op,
    input  logic [WORD*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [WORD-1:0]            rsp_data,
    output logic                       rsp_err,
    output logic [WORD-1:0]            stk_din,
    input  logic [WORD-1:0]            stk_peak,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDW   = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   id_q;
    op_e              op_q;
    logic             rej_q;
    logic [WORD-1:0]  din_q, rsp_q;
    logic [CNT_W-1:0] depth_q, depth_d;

    logic [NREQ-1:0]  grant;
    logic             accept;
    logic [IDW-1:0]   sel_id;
    op_e              sel_op;
    logic [WORD-1:0]  sel_data;
    logic             sel_rej;
    logic             is_full, is_empty;

    assign is_full  = (depth_q == CNT_W'(DEPTH));
    assign is_empty = (depth_q == '0);
    assign accept   = (state_q == IDLE) && (|req_valid);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (accept),
        .grant_o   (grant)
    );

    always_comb begin
        sel_id   = '0;
        sel_op   = PUSH;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_id   = IDW'(i);
                sel_op   = op_e'(req_op[2*i +: 2]);
                sel_data = req_data[WORD*i +: WORD];
            end
        end
    end

`ifdef STACK_CTL_GUARD_EN
    assign sel_rej = (grows_stack(sel_op) && is_full) || ((sel_op != PUSH) && is_empty);
`else
    assign sel_rej = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (sel_op == PEEK || sel_rej) ? DONE : EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? grant : '0;
        stk_push  = (state_q == EXEC) && grows_stack(op_q);
        stk_pop   = (state_q == EXEC) && (op_q == POP);
        rsp_data  = (state_q == DONE) ? rsp_q : '0;
        rsp_err   = (state_q == DONE) && rej_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (state_q == DONE) && (id_q == IDW'(i));
        end
    end

    // Response value is fixed at accept time: the stack top is only valid before the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q  <= '0;
            op_q  <= PUSH;
            rej_q <= 1'b0;
            din_q <= '0;
            rsp_q <= '0;
        end else if (accept) begin
            id_q  <= sel_id;
            op_q  <= sel_op;
            rej_q <= sel_rej;
            din_q <= (sel_op == DUP) ? stk_peak : sel_data;
            rsp_q <= sel_rej ? '0 : ((sel_op == PUSH) ? sel_data : stk_peak);
        end
    end

    always_comb begin
        depth_d = depth_q;
        if (stk_push && !is_full) begin
            depth_d = depth_q + 1'b1;
        end else if (stk_pop && !is_empty) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign stk_din = din_q;
    assign depth   = depth_q;
    assign full    = is_full;
    assign empty   = is_empty;

endmodule

// File: tb/tb_stack_ctl.sv
// Scoreboard bench for stack_ctl: queue-based stack model, RR model, bench-side stack device.
module tb_stack_ctl;
    import stack_ctl_pkg::*;

    localparam int WORD  = 8;
    localparam int DEPTH = 8;
    localparam int NREQ  = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef STACK_CTL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WORD*NREQ-1:0]  req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WORD-1:0]       rsp_data;
    logic                  rsp_err;
    logic [WORD-1:0]       stk_din;
    logic [WORD-1:0]       stk_peak;
    logic                  stk_push;
    logic                  stk_pop;
    logic [CW-1:0]         depth;
    logic                  full;
    logic                  empty;

    stack_ctl #(.WORD(WORD), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .stk_din   (stk_din),
        .stk_peak  (stk_peak),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        int              id;
        logic [WORD-1:0] data;
        bit              err;
        int              acc;
        int              rsp_cyc;
        int              strobe;   // 0 none, 1 push, 2 pop
        logic [WORD-1:0] din;
        int              depth;
    } exp_t;

    exp_t            sb[$];
    logic [WORD-1:0] m_stack[$];
    logic [WORD-1:0] dev_q[$];
    int              m_ptr    = 0;
    int              free_cyc = 0;
    int              cyc      = 0;
    int              tests    = 0;
    int              fails    = 0;
    logic [NREQ-1:0] taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Bench-side stack device; emptied with reset so post-reset reads are deterministic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_q.delete();
            stk_peak <= '0;
        end else begin
            if (stk_push) begin
                dev_q.push_back(stk_din);
                if (dev_q.size() > DEPTH) void'(dev_q.pop_front());
            end else if (stk_pop && dev_q.size() > 0) begin
                void'(dev_q.pop_back());
            end
            stk_peak <= (dev_q.size() > 0) ? dev_q[$] : '0;
        end
    end

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply(input int id, input op_e op, input logic [WORD-1:0] data);
        exp_t e;
        int   size;
        logic [WORD-1:0] top;
        size     = m_stack.size();
        top      = (size > 0) ? m_stack[$] : '0;
        e.id     = id;
        e.acc    = cyc;
        e.err    = 1'b0;
        e.strobe = 0;
        e.din    = '0;
        if (GUARD && (((op == PUSH || op == DUP) && size == DEPTH) || (op != PUSH && size == 0))) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            case (op)
                PUSH: begin e.data = data; e.strobe = 1; e.din = data; m_stack.push_back(data); end
                DUP:  begin e.data = top;  e.strobe = 1; e.din = top;  m_stack.push_back(top);  end
                POP:  begin e.data = top;  e.strobe = 2; if (size > 0) void'(m_stack.pop_back()); end
                default: e.data = top;
            endcase
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
        end
        e.depth   = m_stack.size();
        e.rsp_cyc = cyc + ((e.strobe != 0) ? 2 : 1);
        free_cyc  = e.rsp_cyc + 1;
        m_ptr     = (id + 1) % NREQ;
        taken[id] = 1'b1;
        sb.push_back(e);
    endtask

    // Stimulus side: predict the grant, and on accept push the expected response.
    always @(negedge clk) begin
        int              pick;
        logic [NREQ-1:0] eg;
        pick = -1;
        eg   = '0;
        if (rst_n) begin
            if (cyc >= free_cyc) pick = rr_pick(req_valid, m_ptr);
            if (pick >= 0) eg[pick] = 1'b1;
            if (eg != '0 || req_ready != '0) check("grant", req_ready == eg, 32'(req_ready), 32'(eg));
            if (pick >= 0 && req_ready == eg)
                apply(pick, op_e'(req_op[2*pick +: 2]), req_data[WORD*pick +: WORD]);
        end
    end

    // Monitor: strobes and responses against the scoreboard.
    always @(negedge clk) begin
        bit              ep, eo;
        exp_t            e;
        logic [NREQ-1:0] ev;
        ep = 1'b0;
        eo = 1'b0;
        ev = '0;
        if (rst_n) begin
            if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
                ep = (sb[0].strobe == 1);
                eo = (sb[0].strobe == 2);
            end
            if (ep || eo || stk_push || stk_pop)
                check("strobe", {stk_push, stk_pop} == {ep, eo}, 32'({stk_push, stk_pop}), 32'({ep, eo}));
            if (ep) check("stk_din", stk_din == sb[0].din, 32'(stk_din), 32'(sb[0].din));
            if (sb.size() > 0 && sb[0].strobe == 1 && cyc == sb[0].acc + 2)
                check("stk_din_hold", stk_din == sb[0].din, 32'(stk_din), 32'(sb[0].din));
            if (|rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1'b0, 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    ev[e.id] = 1'b1;
                    check("rsp_id", rsp_valid == ev, 32'(rsp_valid), 32'(ev));
                    check("rsp_cycle", cyc == e.rsp_cyc, 32'(cyc), 32'(e.rsp_cyc));
                    check("rsp_data", rsp_data == e.data, 32'(rsp_data), 32'(e.data));
                    check("rsp_err", rsp_err == e.err, 32'(rsp_err), 32'(e.err));
                    check("depth", int'(depth) == e.depth, 32'(depth), 32'(e.depth));
                    check("flags", {full, empty} == {e.depth == DEPTH, e.depth == 0},
                          32'({full, empty}), 32'({e.depth == DEPTH, e.depth == 0}));
                end
            end else if (sb.size() > 0 && cyc > sb[0].rsp_cyc) begin
                check("rsp_timeout", 1'b0, 32'(cyc), 32'(sb[0].rsp_cyc));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (taken[i]) begin
                req_valid[i] = 1'b0;
                taken[i]     = 1'b0;
            end
        end
    endtask

    task automatic send(input int i, input op_e op, input logic [WORD-1:0] data);
        for (int t = 0; t < 100 && req_valid[i]; t++) step();
        if (req_valid[i]) check("send_timeout", 1'b0, 32'(i), 32'd0);
        req_valid[i]            = 1'b1;
        req_op[2*i +: 2]        = op;
        req_data[WORD*i +: WORD] = data;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (req_valid != '0 || sb.size() != 0); t++) step();
        check("drain", req_valid == '0 && sb.size() == 0, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        taken     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready == '0, 32'(req_ready), 32'd0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data} == '0, 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        check("rst_strobe", {stk_push, stk_pop} == 2'b00, 32'({stk_push, stk_pop}), 32'd0);
        check("rst_din", stk_din == '0, 32'(stk_din), 32'd0);
        check("rst_depth", depth == '0, 32'(depth), 32'd0);
        check("rst_flags", {full, empty} == 2'b01, 32'({full, empty}), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        send(0, PUSH, 8'h11); send(0, PUSH, 8'h22); send(0, PUSH, 8'h33);
        send(0, POP, 8'h00);  send(0, POP, 8'h00);  send(0, POP, 8'h00);
        drain();

        for (int k = 0; k < 4; k++) begin
            send(0, PUSH, 8'hA0 + 8'(k));
            send(1, PUSH, 8'hB0 + 8'(k));
        end
        for (int k = 0; k < 4; k++) begin
            send(0, POP, 8'h00);
            send(1, POP, 8'h00);
        end
        drain();

        send(0, PUSH, 8'h5A); send(0, DUP, 8'h00); send(0, POP, 8'h00); send(0, POP, 8'h00);
        send(1, PUSH, 8'h44); send(1, PEEK, 8'h00); send(1, POP, 8'h00);
        drain();

        for (int k = 0; k <= DEPTH; k++) send(k % NREQ, PUSH, 8'hC0 + 8'(k));
        send(0, PEEK, 8'h00);
        for (int k = 0; k <= DEPTH; k++) send(k % NREQ, POP, 8'h00);
        send(1, POP, 8'h00); send(0, PEEK, 8'h00); send(1, DUP, 8'h00); send(0, POP, 8'h00);
        drain();

        // Reset while a POP strobe is high.
        send(0, PUSH, 8'h77);
        drain();
        send(1, POP, 8'h00);
        for (int t = 0; t < 10 && !stk_pop; t++) @(negedge clk);
        check("pop_seen", stk_pop, 32'(stk_pop), 32'd1);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        taken     = '0;
        sb.delete();
        m_stack.delete();
        m_ptr     = 0;
        free_cyc  = 0;
        #1;
        check("mid_rst_pop", stk_pop == 1'b0, 32'(stk_pop), 32'd0);
        check("mid_rst_rsp", rsp_valid == '0, 32'(rsp_valid), 32'd0);
        check("mid_rst_depth", {depth, empty} == {CW'(0), 1'b1}, 32'({depth, empty}), 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        send(0, PUSH, 8'h3C);
        send(1, PEEK, 8'h00);
        drain();

        repeat (600) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    int r;
                    op_e op;
                    r  = $urandom_range(0, 9);
                    op = (r < 4) ? PUSH : (r == 6) ? DUP : (r == 7) ? PEEK : POP;
                    req_valid[i]             = 1'b1;
                    req_op[2*i +: 2]         = op;
                    req_data[WORD*i +: WORD] = WORD'($urandom);
                end
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
